cpu_mul_pipe_tracker: RTL and testbench



---
 rtl/cpu_mul_pipe_tracker.sv | 117 +++++++++++
 tb/tb_cpu_mul_pipe_tracker.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mul_pipe_tracker.sv
// cpu_mul_pipe_tracker: five-stage multiplier that reports per-stage destination tags to hazard detection.
// The product is accumulated one operand-b chunk per stage so that stage 4 holds the full low product.
module cpu_mul_pipe_tracker #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W = 32,
    parameter int STAGES = 5,
    localparam int RID_W = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic                     issue_wb,
    input  logic [RID_W-1:0]         issue_rd,
    input  logic [DATA_W-1:0]        issue_a,
    input  logic [DATA_W-1:0]        issue_b,
    input  logic                     stall,
    output logic [STAGES-1:0]        stage_wb,
    output logic [STAGES*RID_W-1:0]  stage_rd,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic [RID_W-1:0]         result_rd,
    output logic [DATA_W-1:0]        result_data,
    output logic                     busy,
    output logic [2:0]               occupancy
);
    localparam int NCH = STAGES - 1;
    localparam int CW = (DATA_W + NCH - 1) / NCH;
    localparam int BW = CW * NCH;

    logic [STAGES-1:0] valid_q, valid_d, wb_q, wb_d;
    logic [RID_W-1:0]  rd_q [STAGES];
    logic [RID_W-1:0]  rd_d [STAGES];
    logic [DATA_W-1:0] a_q [STAGES];
    logic [DATA_W-1:0] a_d [STAGES];
    logic [DATA_W-1:0] b_q [STAGES];
    logic [DATA_W-1:0] b_d [STAGES];
    logic [DATA_W-1:0] acc_q [STAGES];
    logic [DATA_W-1:0] acc_d [STAGES];
    logic [2:0]        occ_q, occ_d;
    logic              hold, advance, accept, retire;

    // Chunk k of b times a, aligned to its weight; chunks past the last contribute nothing.
    function automatic logic [DATA_W-1:0] pp(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input int k);
        logic [BW-1:0] bp;
        logic [CW-1:0] c;
        bp = BW'(b);
        c = '0;
        if (k < NCH) c = bp[k*CW +: CW];
        return (a * DATA_W'(c)) << (k*CW);
    endfunction

    assign hold = stall || (valid_q[STAGES-1] && wb_q[STAGES-1] && !result_ready);
    assign advance = !hold;
    assign accept = issue_valid && advance;
    assign retire = advance && valid_q[STAGES-1];
    assign issue_ready = advance;

    always_comb begin
        valid_d = valid_q;
        wb_d = wb_q;
        rd_d = rd_q;
        a_d = a_q;
        b_d = b_q;
        acc_d = acc_q;
        occ_d = occ_q + 3'(accept) - 3'(retire);
        if (advance) begin
            valid_d = {valid_q[STAGES-2:0], accept};
            wb_d = {wb_q[STAGES-2:0], accept && issue_wb && (issue_rd != '0)};
            rd_d[0] = accept ? issue_rd : '0;
            a_d[0] = accept ? issue_a : '0;
            b_d[0] = accept ? issue_b : '0;
            acc_d[0] = accept ? pp(issue_a, issue_b, 0) : '0;
            for (int k = 1; k < STAGES; k++) begin
                rd_d[k] = rd_q[k-1];
                a_d[k] = a_q[k-1];
                b_d[k] = b_q[k-1];
                acc_d[k] = acc_q[k-1] + pp(a_q[k-1], b_q[k-1], k);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            wb_q <= '0;
            occ_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                rd_q[k] <= '0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                acc_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            wb_q <= wb_d;
            occ_q <= occ_d;
            rd_q <= rd_d;
            a_q <= a_d;
            b_q <= b_d;
            acc_q <= acc_d;
        end
    end

    always_comb begin
        stage_wb = valid_q & wb_q;
        stage_rd = '0;
        for (int k = 0; k < STAGES; k++)
            stage_rd[k*RID_W +: RID_W] = stage_wb[k] ? rd_q[k] : '0;
    end

    assign result_valid = valid_q[STAGES-1] && wb_q[STAGES-1] && !stall;
    assign result_rd = result_valid ? rd_q[STAGES-1] : '0;
    assign result_data = result_valid ? acc_q[STAGES-1] : '0;
    assign occupancy = occ_q;
    assign busy = occ_q != '0;
endmodule

// File: tb/tb_cpu_mul_pipe_tracker.sv
// tb_cpu_mul_pipe_tracker: vector table plus hand sequences, results checked through an in-order scoreboard.
module tb_cpu_mul_pipe_tracker;
    logic clk = 0;
    always #5 clk = ~clk;

    logic        reset_n, issue_valid, issue_ready, issue_wb, stall;
    logic [4:0]  issue_rd, result_rd;
    logic [31:0] issue_a, issue_b, result_data;
    logic [4:0]  stage_wb;
    logic [24:0] stage_rd, exp_rd;
    logic        result_valid, result_ready, busy;
    logic [2:0]  occupancy;

    cpu_mul_pipe_tracker dut (
        .clk(clk), .reset_n(reset_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_wb(issue_wb), .issue_rd(issue_rd), .issue_a(issue_a), .issue_b(issue_b),
        .stall(stall), .stage_wb(stage_wb), .stage_rd(stage_rd), .result_valid(result_valid),
        .result_ready(result_ready), .result_rd(result_rd), .result_data(result_data),
        .busy(busy), .occupancy(occupancy)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wb;
        logic        exp_v;
        logic [31:0] exp_d;
    } vec_t;
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } exp_t;

    vec_t tbl [9];
    exp_t sb [$];
    exp_t mon_e;
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int t_acc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && result_valid && result_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got rd %0d data %0h expected none", result_rd, result_data);
            end else begin
                mon_e = sb.pop_front();
                check("result_rd", 64'(result_rd), 64'(mon_e.rd));
                check("result_data", 64'(result_data), 64'(mon_e.d));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0;
        issue_wb = 0;
        issue_rd = 0;
        issue_a = 0;
        issue_b = 0;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd, input logic wb);
        issue_valid = 1;
        issue_a = a;
        issue_b = b;
        issue_rd = rd;
        issue_wb = wb;
    endtask

    task automatic drain();
        idle();
        stall = 0;
        result_ready = 1;
        for (int i = 0; i < 20 && (sb.size() != 0 || occupancy != 0); i++) tick();
        check("drain_queue", 64'(sb.size()), 0);
        check("drain_occ", 64'(occupancy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'd7, 32'd6, 5'd3, 1'b1, 1'b1, 32'd42};
        tbl[1] = '{32'hFFFFFFFF, 32'd2, 5'd4, 1'b1, 1'b1, 32'hFFFFFFFE};
        tbl[2] = '{32'h12345678, 32'h10, 5'd5, 1'b1, 1'b1, 32'h23456780};
        tbl[3] = '{32'h00010000, 32'h00010000, 5'd6, 1'b1, 1'b1, 32'h0};
        tbl[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 1'b1, 1'b1, 32'h1};
        tbl[5] = '{32'd3, 32'd5, 5'd0, 1'b1, 1'b0, 32'h0};
        tbl[6] = '{32'd9, 32'd9, 5'd8, 1'b0, 1'b0, 32'h0};
        tbl[7] = '{32'h0000FFFF, 32'h00010001, 5'd31, 1'b1, 1'b1, 32'hFFFFFFFF};
        tbl[8] = '{32'h80000000, 32'd3, 5'd1, 1'b1, 1'b1, 32'h80000000};

        reset_n = 0;
        stall = 0;
        result_ready = 1;
        idle();
        #3;
        check("rst_stage_wb", 64'(stage_wb), 0);
        check("rst_stage_rd", 64'(stage_rd), 0);
        check("rst_result_valid", 64'(result_valid), 0);
        check("rst_result_data", 64'(result_data), 0);
        check("rst_occ", 64'(occupancy), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_issue_ready", 64'(issue_ready), 1);
        stall = 1;
        #1;
        check("rst_issue_ready_stall", 64'(issue_ready), 0);
        stall = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
        tick();

        t_acc = cyc + 1;
        drive(7, 6, 3, 1);
        sb.push_back('{5'd3, 32'd42});
        for (int k = 0; k < 5; k++) begin
            tick();
            idle();
            @(negedge clk);
            check("single_stage_wb", 64'(stage_wb), 64'(1 << k));
            check("single_stage_rd", 64'(stage_rd[k*5 +: 5]), 3);
            check("single_occ", 64'(occupancy), 1);
            check("single_result_valid", 64'(result_valid), 64'(k == 4));
        end
        check("single_latency", 64'(cyc + 1 - t_acc), 5);
        tick();
        check("single_occ_after", 64'(occupancy), 0);
        check("single_busy_after", 64'(busy), 0);

        result_ready = 0;
        t_acc = cyc + 1;
        for (int i = 1; i <= 5; i++) begin
            drive(32'(i), 32'd10, 5'(i), 1);
            sb.push_back('{5'(i), 32'(10 * i)});
            tick();
        end
        drive(6, 6, 6, 1);
        for (int k = 0; k < 5; k++) exp_rd[k*5 +: 5] = 5'(5 - k);
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            check("bp_occ", 64'(occupancy), 5);
            check("bp_stage_wb", 64'(stage_wb), 64'h1f);
            check("bp_stage_rd", 64'(stage_rd), 64'(exp_rd));
            check("bp_issue_ready", 64'(issue_ready), 0);
            check("bp_result_valid", 64'(result_valid), 1);
            check("bp_result_rd", 64'(result_rd), 1);
            check("bp_result_data", 64'(result_data), 10);
            tick();
        end
        idle();
        result_ready = 1;
        @(negedge clk);
        check("bp_latency", 64'(cyc + 1 - t_acc), 8);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            check("bp_drain_valid", 64'(result_valid), 1);
            check("bp_drain_occ", 64'(occupancy), 64'(4 - i));
        end
        drain();

        drive(3, 5, 0, 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            idle();
            @(negedge clk);
            check("r0_stage_wb", 64'(stage_wb), 0);
            check("r0_result_valid", 64'(result_valid), 0);
            check("r0_occ", 64'(occupancy), 1);
        end
        tick();
        check("r0_retired", 64'(occupancy), 0);

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].wb);
            if (tbl[i].exp_v) sb.push_back('{tbl[i].rd, tbl[i].exp_d});
            tick();
            check("tbl_occ", 64'(occupancy), 64'(i < 5 ? i + 1 : 5));
        end
        drain();

        for (int i = 0; i < 3; i++) begin
            drive(32'(i + 2), 32'd3, 5'(10 + i), 1);
            tick();
        end
        drive(9, 9, 9, 1);
        stall = 1;
        exp_rd = 25'(12) | (25'(11) << 5) | (25'(10) << 10);
        for (int h = 0; h < 2; h++) begin
            @(negedge clk);
            check("stall_occ", 64'(occupancy), 3);
            check("stall_stage_wb", 64'(stage_wb), 64'h07);
            check("stall_stage_rd", 64'(stage_rd), 64'(exp_rd));
            check("stall_issue_ready", 64'(issue_ready), 0);
            check("stall_result_valid", 64'(result_valid), 0);
            tick();
        end
        #2;
        reset_n = 0;
        #1;
        check("midrst_stage_wb", 64'(stage_wb), 0);
        check("midrst_stage_rd", 64'(stage_rd), 0);
        check("midrst_result_valid", 64'(result_valid), 0);
        check("midrst_occ", 64'(occupancy), 0);
        check("midrst_busy", 64'(busy), 0);
        check("midrst_issue_ready_stall", 64'(issue_ready), 0);
        stall = 0;
        #1;
        check("midrst_issue_ready", 64'(issue_ready), 1);
        idle();
        repeat (2) tick();
        reset_n = 1;
        tick();
        check("post_rst_occ", 64'(occupancy), 0);
        check("post_rst_queue", 64'(sb.size()), 0);

        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
